// File: rtl/reg_bank_32x32_if.sv
// ---------------------------------------------------------------------------
// reg_bank_32x32_if
// Bus bundle between the register bank and whoever drives it.
//   WrEn/WrAddr/WrData : single synchronous write port
//   ClrReq             : request a bulk clear of the whole bank
//   Busy               : high while the clear sequence walks the bank
//   ClrDone            : one-cycle pulse once the last register is cleared
//   WrRej              : one-cycle pulse when a write was dropped by a clear
//   RegOut             : all 32 registers flattened, slice k = register k
// master drives the requests, slave is the register bank itself.
// ---------------------------------------------------------------------------
interface reg_bank_32x32_if #(
    parameter int WIDTH = 32
);
    logic                  WrEn;
    logic [4:0]            WrAddr;
    logic [WIDTH-1:0]      WrData;
    logic                  ClrReq;
    logic                  Busy;
    logic                  ClrDone;
    logic                  WrRej;
    logic [32*WIDTH-1:0]   RegOut;

    modport master (
        output WrEn, WrAddr, WrData, ClrReq,
        input  Busy, ClrDone, WrRej, RegOut
    );

    modport slave (
        input  WrEn, WrAddr, WrData, ClrReq,
        output Busy, ClrDone, WrRej, RegOut
    );
endinterface

// File: rtl/reg_bank_32x32.sv
// ---------------------------------------------------------------------------
// reg_bank_32x32
// Bank of 32 general-purpose registers feeding the 32->1 read multiplexers.
// Every register is visible at once on io_bus.RegOut. One synchronous write
// port, plus a clear engine that loads CLR_VALUE into one register per cycle.
// Ports:
//   i_clk   : rising-edge clock
//   i_rst   : asynchronous, active-high reset (bank to 0, FSM to IDLE)
//   io_bus  : reg_bank_32x32_if slave (write port, clear request, status,
//             flattened register outputs)
// ---------------------------------------------------------------------------
module reg_bank_32x32 #(
    parameter int               WIDTH     = 32,
    parameter bit               ZERO_REG  = 1'b1,
    parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    reg_bank_32x32_if.slave    io_bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [4:0]          r_ptr;
    logic [WIDTH-1:0]    r_regs [32];
    logic                r_wrRej;
    logic                w_busy;
    logic                w_clrDone;
    logic                w_wrAccept;
    logic                w_clrSkip;
    logic [32*WIDTH-1:0] w_regOut;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Busy/ClrDone decode the state register only, so no input reaches them.
    always_comb begin
        w_nextState = r_state;
        w_busy      = 1'b0;
        w_clrDone   = 1'b0;
        case (r_state)
            IDLE: begin
                if (io_bus.ClrReq) begin
                    w_nextState = CLEAR;
                end
            end
            CLEAR: begin
                w_busy = 1'b1;
                if (r_ptr == 5'd31) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_clrDone   = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // The pointer wraps 31 -> 0 on the same edge that leaves CLEAR.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= 5'd0;
        end else if ((r_state == IDLE) && io_bus.ClrReq) begin
            r_ptr <= 5'd0;
        end else if (r_state == CLEAR) begin
            r_ptr <= r_ptr + 5'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wrRej <= 1'b0;
        end else begin
            r_wrRej <= io_bus.WrEn && (r_state != IDLE);
        end
    end

    // Writes to the hardwired zero register are dropped without a reject
    // pulse; the clear slot for it still takes its cycle but writes nothing.
    assign w_wrAccept = (r_state == IDLE) && io_bus.WrEn &&
                        !(ZERO_REG && (io_bus.WrAddr == 5'd0));
    assign w_clrSkip  = ZERO_REG && (r_ptr == 5'd0);

    // Write and clear live in different states, so they never collide.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < 32; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            if (w_wrAccept) begin
                r_regs[io_bus.WrAddr] <= io_bus.WrData;
            end
            if ((r_state == CLEAR) && !w_clrSkip) begin
                r_regs[r_ptr] <= CLR_VALUE;
            end
        end
    end

    always_comb begin
        w_regOut = '0;
        for (int k = 0; k < 32; k++) begin
            w_regOut[k*WIDTH +: WIDTH] = r_regs[k];
        end
        if (ZERO_REG) begin
            w_regOut[WIDTH-1:0] = '0;
        end
    end

    assign io_bus.Busy    = w_busy;
    assign io_bus.ClrDone = w_clrDone;
    assign io_bus.WrRej   = r_wrRej;
    assign io_bus.RegOut  = w_regOut;

endmodule

// File: tb/tb_reg_bank_32x32.sv
// ---------------------------------------------------------------------------
// tb_reg_bank_32x32
// Self-checking bench for reg_bank_32x32 (WIDTH=32, ZERO_REG=1, CLR_VALUE=0).
// A reference model tracks the bank as a plain array and the clear sequence
// as a step count (-1 idle, 0..31 clearing slot n, 32 done pulse).
// ---------------------------------------------------------------------------
module tb_reg_bank_32x32;

    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;

    reg_bank_32x32_if #(.WIDTH(WIDTH)) bus ();

    reg_bank_32x32 #(
        .WIDTH     (WIDTH),
        .ZERO_REG  (1'b1),
        .CLR_VALUE ('0)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [WIDTH-1:0] modelRegs [32];
    int               modelSeq;
    logic             modelRej;

    typedef struct {
        logic        wrEn;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] expVal;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [WIDTH-1:0] regOf(input int k);
        return bus.RegOut[k*WIDTH +: WIDTH];
    endfunction

    function automatic void modelReset();
        for (int k = 0; k < 32; k++) modelRegs[k] = '0;
        modelSeq = -1;
        modelRej = 1'b0;
    endfunction

    // One rising edge of the specified behaviour.
    function automatic void modelEdge(input logic wrEn, input logic [4:0] addr,
                                      input logic [31:0] data, input logic clr);
        modelRej = wrEn && (modelSeq != -1);
        if (modelSeq == -1) begin
            if (wrEn && (addr != 5'd0)) modelRegs[addr] = data;
            if (clr) modelSeq = 0;
        end else if (modelSeq < 32) begin
            if (modelSeq != 0) modelRegs[modelSeq] = '0;
            modelSeq = modelSeq + 1;
        end else begin
            modelSeq = -1;
        end
    endfunction

    task automatic checkBit(input string name, input logic act, input logic exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic checkWord(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        int bad = -1;
        checkBit("busy", bus.Busy, (modelSeq >= 0) && (modelSeq < 32));
        checkBit("clrdone", bus.ClrDone, modelSeq == 32);
        checkBit("wrrej", bus.WrRej, modelRej);
        for (int k = 0; k < 32; k++) begin
            if ((regOf(k) !== modelRegs[k]) && (bad < 0)) bad = k;
        end
        testsRun++;
        if (bad >= 0) begin
            testsFailed++;
            $display("[TB] FAIL regout reg%0d: got %h expected %h", bad, regOf(bad), modelRegs[bad]);
        end
    endtask

    task automatic applyStimulus(input logic wrEn, input logic [4:0] addr,
                                 input logic [31:0] data, input logic clr);
        bus.WrEn   = wrEn;
        bus.WrAddr = addr;
        bus.WrData = data;
        bus.ClrReq = clr;
        @(posedge clk);
        modelEdge(wrEn, addr, data, clr);
        #1;
        checkOutput();
    endtask

    task automatic idleSteps(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
    endtask

    // Asynchronous reset applied mid-cycle; outputs checked before any edge.
    task automatic pulseReset();
        bus.WrEn   = 1'b0;
        bus.ClrReq = 1'b0;
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput();
        checkWord("reset_reg9", regOf(9), 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int busyCount;
        int doneCount;

        bus.WrEn   = 1'b0;
        bus.WrAddr = 5'd0;
        bus.WrData = 32'h0;
        bus.ClrReq = 1'b0;

        // Reset state
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput();
        @(negedge clk);
        rst = 1'b0;

        // Table-driven IDLE writes with hand-computed register values
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 5'd0,  32'h12345678, 32'h00000000};
        vecs[2] = '{1'b1, 5'd31, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[3] = '{1'b1, 5'd5,  32'h00000001, 32'h00000001};
        vecs[4] = '{1'b0, 5'd5,  32'hFFFFFFFF, 32'h00000001};
        vecs[5] = '{1'b1, 5'd1,  32'hCAFEF00D, 32'hCAFEF00D};
        vecs[6] = '{1'b0, 5'd31, 32'h00000000, 32'hA5A5A5A5};
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].wrEn, vecs[i].addr, vecs[i].data, 1'b0);
            checkWord($sformatf("vec%0d", i), regOf(int'(vecs[i].addr)), vecs[i].expVal);
        end

        // Fill with k+1, then a full clear sequence
        for (int k = 0; k < 32; k++) applyStimulus(1'b1, 5'(k), 32'(k + 1), 1'b0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
        busyCount = (bus.Busy === 1'b1) ? 1 : 0;
        doneCount = (bus.ClrDone === 1'b1) ? 1 : 0;
        for (int s = 1; s <= 33; s++) begin
            if (s <= 31) checkWord($sformatf("clr_intact%0d", s), regOf(s), 32'(s + 1));
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
            if (bus.Busy === 1'b1) busyCount++;
            if (bus.ClrDone === 1'b1) doneCount++;
        end
        checkWord("busy_cycles", 32'(busyCount), 32'd32);
        checkWord("done_pulses", 32'(doneCount), 32'd1);

        // Write during clear cycle 10 is rejected
        applyStimulus(1'b1, 5'd7, 32'h00000077, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
        idleSteps(9);
        applyStimulus(1'b1, 5'd7, 32'h00000BAD, 1'b0);
        checkBit("rej_pulse", bus.WrRej, 1'b1);
        checkWord("rej_reg7", regOf(7), 32'h0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
        checkBit("rej_single", bus.WrRej, 1'b0);
        idleSteps(24);
        checkWord("rej_reg7_end", regOf(7), 32'h0);

        // Write and clear request in the same IDLE cycle
        applyStimulus(1'b1, 5'd3, 32'h00000055, 1'b1);
        checkWord("simul_reg3", regOf(3), 32'h55);
        checkBit("simul_busy", bus.Busy, 1'b1);
        idleSteps(33);
        checkWord("simul_reg3_end", regOf(3), 32'h0);

        // Reset mid-clear, then a fresh clear restarts at pointer 0
        applyStimulus(1'b1, 5'd9, 32'h00000099, 1'b0);
        applyStimulus(1'b1, 5'd20, 32'h00000020, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
        idleSteps(14);
        pulseReset();
        applyStimulus(1'b1, 5'd2, 32'h00000022, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
        idleSteps(2);
        checkWord("restart_reg2_pre", regOf(2), 32'h22);
        idleSteps(1);
        checkWord("restart_reg2_post", regOf(2), 32'h0);
        idleSteps(31);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                          32'($urandom), ($urandom_range(0, 19) == 0));
        end
        pulseReset();
        idleSteps(2);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
